mips_run_ctrl: RTL and testbench

MIPS_RUN_CTRL -- requirements
Module: mips_run_ctrl

---
 rtl/mips_run_ctrl.sv | 166 ++++++++++++++++
 tb/tb_mips_run_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_run_ctrl.sv
// Run controller for a MIPS core under test: resets the CPU, lets it run,
// detects halt on a stalled PC or a cycle budget, and counts write strobes.
module mips_run_ctrl #(
  parameter int PC_W        = 32,
  parameter int CNT_W       = 32,
  parameter int RST_CYCLES  = 1,
  parameter int MAX_CYCLES  = 300,
  parameter int HALT_REPEAT = 3
) (
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  input  logic [PC_W-1:0]  pc,
  input  logic             reg_write,
  input  logic             mem_write,
  output logic             cpu_res,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] regwr_cnt,
  output logic [CNT_W-1:0] memwr_cnt
);

  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int MW = $clog2(HALT_REPEAT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_HALTED,
    S_TIMEOUT
  } state_t;

  state_t st, st_d;

  logic [RW-1:0]    rst_cnt, rst_cnt_d;
  logic [MW-1:0]    mcnt, mcnt_d;
  logic [PC_W-1:0]  pc_q, pc_q_d;
  logic             pc_valid, pc_valid_d;
  logic             cpu_res_d, running_d;
  logic             done_d, timeout_d;
  logic [CNT_W-1:0] cyc_d, rw_d, mw_d;

  logic             match_hit;
  logic [MW-1:0]    mcnt_inc;
  logic             halt_hit;
  logic [CNT_W-1:0] cyc_inc;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign match_hit = pc_valid && (pc == pc_q);
  assign mcnt_inc  = mcnt + MW'(1);
  assign halt_hit  = match_hit && (mcnt_inc == MW'(HALT_REPEAT));
  assign cyc_inc   = sat_inc(cycle_cnt);

  always_comb begin
    st_d       = st;
    rst_cnt_d  = rst_cnt;
    mcnt_d     = mcnt;
    pc_q_d     = pc_q;
    pc_valid_d = pc_valid;
    cpu_res_d  = cpu_res;
    running_d  = running;
    done_d     = done;
    timeout_d  = timeout;
    cyc_d      = cycle_cnt;
    rw_d       = regwr_cnt;
    mw_d       = memwr_cnt;

    unique case (st)
      S_IDLE, S_HALTED, S_TIMEOUT: begin
        cpu_res_d = 1'b1;
        running_d = 1'b0;
        if (start) begin
          st_d       = S_RESET;
          rst_cnt_d  = '0;
          mcnt_d     = '0;
          pc_valid_d = 1'b0;
          done_d     = 1'b0;
          timeout_d  = 1'b0;
          cyc_d      = '0;
          rw_d       = '0;
          mw_d       = '0;
        end
      end

      S_RESET: begin
        cpu_res_d = 1'b1;
        running_d = 1'b0;
        if (rst_cnt == RW'(RST_CYCLES - 1)) begin
          st_d      = S_RUN;
          cpu_res_d = 1'b0;
          running_d = 1'b1;
        end else begin
          rst_cnt_d = rst_cnt + RW'(1);
        end
      end

      S_RUN: begin
        cyc_d      = cyc_inc;
        pc_q_d     = pc;
        pc_valid_d = 1'b1;
        if (reg_write) rw_d = sat_inc(regwr_cnt);
        if (mem_write) mw_d = sat_inc(memwr_cnt);
        mcnt_d = match_hit ? mcnt_inc : '0;
        // Halt takes priority over a budget expiring in the same cycle
        if (halt_hit) begin
          st_d      = S_HALTED;
          done_d    = 1'b1;
          timeout_d = 1'b0;
          cpu_res_d = 1'b1;
          running_d = 1'b0;
        end else if (cyc_inc == CNT_W'(MAX_CYCLES)) begin
          st_d      = S_TIMEOUT;
          done_d    = 1'b1;
          timeout_d = 1'b1;
          cpu_res_d = 1'b1;
          running_d = 1'b0;
        end
      end

      default: begin
        st_d      = S_IDLE;
        cpu_res_d = 1'b1;
        running_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      st        <= S_IDLE;
      rst_cnt   <= '0;
      mcnt      <= '0;
      pc_q      <= '0;
      pc_valid  <= 1'b0;
      cpu_res   <= 1'b1;
      running   <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      cycle_cnt <= '0;
      regwr_cnt <= '0;
      memwr_cnt <= '0;
    end else begin
      st        <= st_d;
      rst_cnt   <= rst_cnt_d;
      mcnt      <= mcnt_d;
      pc_q      <= pc_q_d;
      pc_valid  <= pc_valid_d;
      cpu_res   <= cpu_res_d;
      running   <= running_d;
      done      <= done_d;
      timeout   <= timeout_d;
      cycle_cnt <= cyc_d;
      regwr_cnt <= rw_d;
      memwr_cnt <= mw_d;
    end
  end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Bench for mips_run_ctrl: directed runs checked against a run-history
// model every cycle, plus literal expectations at key points.
module tb_mips_run_ctrl;

  localparam int PC_W = 32;
  localparam int CNT_W = 32;
  localparam int RST_CYCLES = 2;
  localparam int MAX_CYCLES = 20;
  localparam int HALT_REPEAT = 3;

  logic             clk = 1'b0;
  logic             res;
  logic             start;
  logic [PC_W-1:0]  pc;
  logic             reg_write;
  logic             mem_write;
  logic             cpu_res;
  logic             running;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] regwr_cnt;
  logic [CNT_W-1:0] memwr_cnt;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  mips_run_ctrl #(
    .PC_W(PC_W),
    .CNT_W(CNT_W),
    .RST_CYCLES(RST_CYCLES),
    .MAX_CYCLES(MAX_CYCLES),
    .HALT_REPEAT(HALT_REPEAT)
  ) dut (
    .clk(clk),
    .res(res),
    .start(start),
    .pc(pc),
    .reg_write(reg_write),
    .mem_write(mem_write),
    .cpu_res(cpu_res),
    .running(running),
    .done(done),
    .timeout(timeout),
    .cycle_cnt(cycle_cnt),
    .regwr_cnt(regwr_cnt),
    .memwr_cnt(memwr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  // Model: phase of the run plus the history of PCs seen this run
  localparam int M_IDLE = 0, M_RESET = 1, M_RUN = 2, M_HALT = 3, M_TO = 4;
  int m_mode = M_IDLE;
  int m_rleft = 0;
  int m_cyc = 0, m_rw = 0, m_mw = 0;
  bit m_cpu_res = 1'b1, m_running = 1'b0, m_done = 1'b0, m_to = 1'b0;
  logic [PC_W-1:0] hist[$];

  function automatic int trailing_same();
    int k = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != hist[hist.size()-1]) break;
      k++;
    end
    return k;
  endfunction

  always @(posedge clk) begin
    if (res) begin
      m_mode = M_IDLE;
      m_cyc = 0; m_rw = 0; m_mw = 0;
      m_cpu_res = 1'b1; m_running = 1'b0;
      m_done = 1'b0; m_to = 1'b0;
      hist.delete();
    end else begin
      case (m_mode)
        M_IDLE, M_HALT, M_TO: begin
          if (start) begin
            m_mode = M_RESET;
            m_rleft = RST_CYCLES;
            m_cyc = 0; m_rw = 0; m_mw = 0;
            m_done = 1'b0; m_to = 1'b0;
            hist.delete();
          end
        end
        M_RESET: begin
          m_rleft--;
          if (m_rleft == 0) begin
            m_mode = M_RUN;
            m_cpu_res = 1'b0;
            m_running = 1'b1;
          end
        end
        M_RUN: begin
          m_cyc++;
          if (reg_write) m_rw++;
          if (mem_write) m_mw++;
          hist.push_back(pc);
          // HALT_REPEAT matches means HALT_REPEAT+1 identical PCs in a row
          if (trailing_same() >= HALT_REPEAT + 1) begin
            m_mode = M_HALT;
            m_done = 1'b1;
            m_cpu_res = 1'b1;
            m_running = 1'b0;
          end else if (m_cyc == MAX_CYCLES) begin
            m_mode = M_TO;
            m_done = 1'b1;
            m_to = 1'b1;
            m_cpu_res = 1'b1;
            m_running = 1'b0;
          end
        end
        default: m_mode = M_IDLE;
      endcase
    end
  end

  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      chk("m_cpu_res", 64'(cpu_res), 64'(m_cpu_res));
      chk("m_running", 64'(running), 64'(m_running));
      chk("m_done", 64'(done), 64'(m_done));
      chk("m_timeout", 64'(timeout), 64'(m_to));
      chk("m_cycle_cnt", 64'(cycle_cnt), 64'(m_cyc));
      chk("m_regwr_cnt", 64'(regwr_cnt), 64'(m_rw));
      chk("m_memwr_cnt", 64'(memwr_cnt), 64'(m_mw));
    end
  end

  // Leaves the caller at the negedge before the first RUN cycle edge
  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("rst_cpu_res_1", 64'(cpu_res), 64'd1);
    chk("rst_done_clr", 64'(done), 64'd0);
    chk("rst_cyc_clr", 64'(cycle_cnt), 64'd0);
    @(negedge clk);
    chk("rst_cpu_res_2", 64'(cpu_res), 64'd1);
    @(negedge clk);
    chk("run_cpu_res", 64'(cpu_res), 64'd0);
    chk("run_running", 64'(running), 64'd1);
  endtask

  task automatic step(input logic [PC_W-1:0] p, input logic rw,
                      input logic mw);
    pc = p;
    reg_write = rw;
    mem_write = mw;
    @(negedge clk);
  endtask

  logic [PC_W-1:0] halt_pcs[7] = '{32'h0, 32'h4, 32'h8, 32'hC,
                                   32'hC, 32'hC, 32'hC};
  logic [PC_W-1:0] strb_pcs[8] = '{32'h10, 32'h14, 32'h18, 32'h1C,
                                   32'h20, 32'h20, 32'h20, 32'h20};
  logic [7:0] rw_pat = 8'b1010_1101;
  logic [7:0] mw_pat = 8'b0001_0010;

  initial begin
    res = 1'b1; start = 1'b0; pc = '0;
    reg_write = 1'b0; mem_write = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp_en = 1'b1;
    chk("reset_cpu_res", 64'(cpu_res), 64'd1);
    chk("reset_running", 64'(running), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_cycle_cnt", 64'(cycle_cnt), 64'd0);
    chk("reset_regwr_cnt", 64'(regwr_cnt), 64'd0);
    res = 1'b0;
    @(negedge clk);

    do_start();
    for (int i = 0; i < 7; i++) step(halt_pcs[i], 1'b0, 1'b0);
    chk("halt_done", 64'(done), 64'd1);
    chk("halt_timeout", 64'(timeout), 64'd0);
    chk("halt_cycle_cnt", 64'(cycle_cnt), 64'd7);
    chk("halt_cpu_res", 64'(cpu_res), 64'd1);

    do_start();
    for (int i = 0; i < 8; i++) begin
      start = (i == 2);
      step(strb_pcs[i], rw_pat[i], mw_pat[i]);
    end
    start = 1'b0;
    chk("strb_regwr", 64'(regwr_cnt), 64'd5);
    chk("strb_memwr", 64'(memwr_cnt), 64'd2);
    chk("strb_cycle_cnt", 64'(cycle_cnt), 64'd8);
    for (int i = 0; i < 4; i++) step(32'h40 + 32'(4 * i), 1'b1, 1'b1);
    chk("strb_regwr_frozen", 64'(regwr_cnt), 64'd5);
    chk("strb_memwr_frozen", 64'(memwr_cnt), 64'd2);

    do_start();
    for (int i = 0; i < 20; i++) step(32'(4 * i), 1'(i % 2), 1'b0);
    chk("to_done", 64'(done), 64'd1);
    chk("to_timeout", 64'(timeout), 64'd1);
    chk("to_cycle_cnt", 64'(cycle_cnt), 64'd20);
    chk("to_regwr", 64'(regwr_cnt), 64'd10);
    for (int i = 0; i < 5; i++) step(32'(100 + 4 * i), 1'b1, 1'b1);
    chk("to_cycle_frozen", 64'(cycle_cnt), 64'd20);
    chk("to_regwr_frozen", 64'(regwr_cnt), 64'd10);
    chk("to_memwr_frozen", 64'(memwr_cnt), 64'd0);

    do_start();
    for (int i = 0; i < 20; i++)
      step((i < 16) ? 32'(8 * i) : 32'h200, 1'b0, 1'b0);
    chk("tie_done", 64'(done), 64'd1);
    chk("tie_timeout", 64'(timeout), 64'd0);
    chk("tie_cycle_cnt", 64'(cycle_cnt), 64'd20);

    do_start();
    for (int i = 0; i < 3; i++) step(32'(4 * i), 1'b1, 1'b1);
    res = 1'b1;
    step(32'hC, 1'b1, 1'b1);
    res = 1'b0;
    chk("midrst_cycle_cnt", 64'(cycle_cnt), 64'd0);
    chk("midrst_regwr", 64'(regwr_cnt), 64'd0);
    chk("midrst_running", 64'(running), 64'd0);
    chk("midrst_cpu_res", 64'(cpu_res), 64'd1);
    step(32'h0, 1'b0, 1'b0);

    do_start();
    for (int i = 0; i < 5; i++) step(32'h80, 1'b0, 1'b1);
    chk("rerun_cycle_cnt", 64'(cycle_cnt), 64'd4);
    chk("rerun_memwr", 64'(memwr_cnt), 64'd4);
    chk("rerun_done", 64'(done), 64'd1);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
